multicycle_datapath: RTL and testbench

- Clocked, parametrised successor of the single-cycle datapath: register file, sign-extend, ALU, data memory and write-back mux, sequenced by an FSM over DECODE/EXECUTE/MEM/WB.
- Accepts one instruction plus its decoded control word through a valid/ready handshake and pulses `done` with status flags when the instruction retires.
- Sits between the future control/fetch unit and the testbench.

---
 rtl/multicycle_datapath_if.sv | 33 +++
 rtl/multicycle_datapath.sv | 174 +++++++++++++++++
 tb/tb_multicycle_datapath.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_datapath_if.sv
// Instruction issue and retire bundle of the multicycle datapath.
// The issuer drives the instruction and control word, the datapath reports retirement.
interface multicycle_datapath_if #(
    parameter int DATA_W = 32
);
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instruction;
    logic              RegDst;
    logic              ALUSrc;
    logic              MemRead;
    logic              MemWrite;
    logic              MemtoReg;
    logic              RegWrite;
    logic [3:0]        ALUCtrl;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              ovf;
    logic              fault;

    modport master (
        output instr_valid, instruction, RegDst, ALUSrc, MemRead,
               MemWrite, MemtoReg, RegWrite, ALUCtrl,
        input  instr_ready, done, result, zero, ovf, fault
    );

    modport slave (
        input  instr_valid, instruction, RegDst, ALUSrc, MemRead,
               MemWrite, MemtoReg, RegWrite, ALUCtrl,
        output instr_ready, done, result, zero, ovf, fault
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: register file, ALU, data memory and
// write-back sequenced through DECODE/EXECUTE/MEM/WB.
module multicycle_datapath #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_datapath_if.slave  bus,
    input  logic [REG_AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, MEM, WB} state_t;

    state_t state;

    logic [REG_AW-1:0] rs, rt, rd;
    logic [15:0]       imm16;
    logic              regdst, alusrc, memread, memwrite, memtoreg, regwrite;
    logic [3:0]        aluctrl;

    logic [DATA_W-1:0] a, b, imm, aluout, mdr;
    logic              zf, of, mflt;

    logic [DATA_W-1:0] regs [2**REG_AW];
    logic [DATA_W-1:0] mem  [2**MEM_AW];

    logic [DATA_W-1:0] op2, alu_res, hi_bits, mdr_nxt, wbv;
    logic              alu_ovf, alu_ill, mem_flt;
    logic [MEM_AW-1:0] maddr;
    logic [REG_AW-1:0] dst;

    assign bus.instr_ready = (state == IDLE);
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

    assign op2 = alusrc ? imm : b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (aluctrl)
            4'b0000: alu_res = a & op2;
            4'b0001: alu_res = a | op2;
            4'b0010: begin
                alu_res = a + op2;
                alu_ovf = (a[DATA_W-1] == op2[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a[DATA_W-1]);
            end
            4'b0110: begin
                alu_res = a - op2;
                alu_ovf = (a[DATA_W-1] != op2[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != a[DATA_W-1]);
            end
            4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(op2))};
            4'b1100: alu_res = ~(a | op2);
            default: alu_ill = 1'b1;
        endcase
    end

    // Memory is word addressed; any bit above the index field is out of range.
    assign maddr   = aluout[MEM_AW+1:2];
    assign hi_bits = aluout >> (MEM_AW + 2);
    assign mem_flt = (aluout[1:0] != 2'b00) || (hi_bits != '0) ||
                     (memread && memwrite);
    assign mdr_nxt = (memread && !mem_flt) ? mem[maddr] : '0;

    assign dst = regdst ? rd : rt;
    assign wbv = memtoreg ? mdr : aluout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rs         <= '0;
            rt         <= '0;
            rd         <= '0;
            imm16      <= '0;
            regdst     <= 1'b0;
            alusrc     <= 1'b0;
            memread    <= 1'b0;
            memwrite   <= 1'b0;
            memtoreg   <= 1'b0;
            regwrite   <= 1'b0;
            aluctrl    <= '0;
            a          <= '0;
            b          <= '0;
            imm        <= '0;
            aluout     <= '0;
            mdr        <= '0;
            zf         <= 1'b0;
            of         <= 1'b0;
            mflt       <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.zero   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.fault  <= 1'b0;
            for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
            for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        rs       <= bus.instruction[21 +: REG_AW];
                        rt       <= bus.instruction[16 +: REG_AW];
                        rd       <= bus.instruction[11 +: REG_AW];
                        imm16    <= bus.instruction[15:0];
                        regdst   <= bus.RegDst;
                        alusrc   <= bus.ALUSrc;
                        memread  <= bus.MemRead;
                        memwrite <= bus.MemWrite;
                        memtoreg <= bus.MemtoReg;
                        regwrite <= bus.RegWrite;
                        aluctrl  <= bus.ALUCtrl;
                        mdr      <= '0;
                        mflt     <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    a     <= (rs == '0) ? '0 : regs[rs];
                    b     <= (rt == '0) ? '0 : regs[rt];
                    imm   <= DATA_W'($signed(imm16));
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    aluout <= alu_res;
                    zf     <= (alu_res == '0);
                    of     <= alu_ovf;
                    // An illegal op retires here with no memory or register side effect.
                    if (!alu_ill && (memread || memwrite)) begin
                        state <= MEM;
                    end else if (!alu_ill && regwrite) begin
                        state <= WB;
                    end else begin
                        state      <= IDLE;
                        bus.done   <= 1'b1;
                        bus.result <= memtoreg ? mdr : alu_res;
                        bus.zero   <= (alu_res == '0);
                        bus.ovf    <= alu_ovf;
                        bus.fault  <= alu_ill;
                    end
                end
                MEM: begin
                    mflt <= mem_flt;
                    mdr  <= mdr_nxt;
                    if (memwrite && !mem_flt) mem[maddr] <= b;
                    if (regwrite) begin
                        state <= WB;
                    end else begin
                        state      <= IDLE;
                        bus.done   <= 1'b1;
                        bus.result <= memtoreg ? mdr_nxt : aluout;
                        bus.zero   <= zf;
                        bus.ovf    <= of;
                        bus.fault  <= mem_flt;
                    end
                end
                WB: begin
                    if (dst != '0 && !(mflt && memtoreg)) regs[dst] <= wbv;
                    state      <= IDLE;
                    bus.done   <= 1'b1;
                    bus.result <= wbv;
                    bus.zero   <= zf;
                    bus.ovf    <= of;
                    bus.fault  <= mflt;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: directed instructions with
// hand-computed retire values, latencies and register contents.
module tb_multicycle_datapath;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    multicycle_datapath_if #(.DATA_W(32)) bus ();

    multicycle_datapath #(.DATA_W(32), .REG_AW(5), .MEM_AW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}
    localparam logic [5:0] C_R   = 6'b100001;
    localparam logic [5:0] C_I   = 6'b010001;
    localparam logic [5:0] C_LW  = 6'b011011;
    localparam logic [5:0] C_SW  = 6'b010100;
    localparam logic [5:0] C_RW  = 6'b011100;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_NOR = 4'b1100;
    localparam logic [3:0] A_BAD = 4'b1111;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        f;
        int          lat;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;
    int   cyc = 0;
    int   tcyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_done: got result %h expected no done",
                         bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".result"}, bus.result, e.res);
                chk({e.name, ".zero"}, 32'(bus.zero), 32'(e.z));
                chk({e.name, ".ovf"}, 32'(bus.ovf), 32'(e.o));
                chk({e.name, ".fault"}, 32'(bus.fault), 32'(e.f));
                chk({e.name, ".latency"}, 32'(cyc - e.t), 32'(e.lat));
            end
        end
    end

    function automatic logic [31:0] mkr(input logic [4:0] rs, rt, rd);
        return {6'b0, rs, rt, rd, 11'b0};
    endfunction

    function automatic logic [31:0] mki(input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
        return {6'b0, rs, rt, imm};
    endfunction

    task automatic send(input logic [31:0] ins, input logic [5:0] c,
                        input logic [3:0] alu);
        int n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
        bus.instruction = ins;
        {bus.RegDst, bus.ALUSrc, bus.MemRead, bus.MemWrite,
         bus.MemtoReg, bus.RegWrite} = c;
        bus.ALUCtrl = alu;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instruction = $urandom;
        bus.ALUCtrl = 4'($urandom);
        tcyc = cyc;
    endtask

    task automatic issue(input string name, input logic [31:0] ins,
                         input logic [5:0] c, input logic [3:0] alu,
                         input logic [31:0] res, input logic z, o, f,
                         input int lat);
        exp_t e;
        send(ins, c, alu);
        e.name = name;
        e.res = res;
        e.z = z;
        e.o = o;
        e.f = f;
        e.lat = lat;
        e.t = tcyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !bus.instr_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reg(input string name, input logic [4:0] r,
                           input logic [31:0] exp);
        dbg_addr = r;
        #1;
        chk(name, dbg_data, exp);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        {bus.RegDst, bus.ALUSrc, bus.MemRead, bus.MemWrite,
         bus.MemtoReg, bus.RegWrite} = '0;
        bus.ALUCtrl = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", 32'(bus.instr_ready), 32'd1);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.flags", {29'd0, bus.zero, bus.ovf, bus.fault}, 32'd0);

        send(mki(5'd0, 5'd1, 16'h0005), C_I, A_ADD);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.ready", 32'(bus.instr_ready), 32'd1);
        chk("abort.flags", {28'd0, bus.done, bus.zero, bus.ovf, bus.fault}, 32'd0);
        chk_reg("abort.r1", 5'd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk_reg("abort.r1_after", 5'd1, 32'd0);

        issue("addi_r1", mki(5'd0, 5'd1, 16'h0005), C_I, A_ADD,
              32'd5, 1'b0, 1'b0, 1'b0, 3);
        issue("addi_r2", mki(5'd0, 5'd2, 16'hFFFE), C_I, A_ADD,
              32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 3);
        issue("sub_r3", mkr(5'd1, 5'd2, 5'd3), C_R, A_SUB,
              32'd7, 1'b0, 1'b0, 1'b0, 3);
        wait_idle();
        chk_reg("r1", 5'd1, 32'd5);
        chk_reg("r2", 5'd2, 32'hFFFFFFFE);
        chk_reg("r3", 5'd3, 32'd7);

        issue("sw", mki(5'd0, 5'd1, 16'h0008), C_SW, A_ADD,
              32'd8, 1'b0, 1'b0, 1'b0, 3);
        issue("lw_r4", mki(5'd0, 5'd4, 16'h0008), C_LW, A_ADD,
              32'd5, 1'b0, 1'b0, 1'b0, 4);
        wait_idle();
        chk_reg("r4", 5'd4, 32'd5);

        issue("seed_r7", mki(5'd0, 5'd7, 16'h4000), C_I, A_ADD,
              32'h4000, 1'b0, 1'b0, 1'b0, 3);
        for (int k = 1; k <= 17; k++)
            issue($sformatf("dbl%0d", k), mkr(5'd7, 5'd7, 5'd7), C_R, A_ADD,
                  32'h4000 << k, 1'b0, (k == 17), 1'b0, 3);
        issue("nor_r7", mkr(5'd7, 5'd0, 5'd7), C_R, A_NOR,
              32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 3);
        issue("ovf_add", mki(5'd7, 5'd8, 16'h0001), C_I, A_ADD,
              32'h80000000, 1'b0, 1'b1, 1'b0, 3);
        issue("sub_zero", mkr(5'd1, 5'd1, 5'd9), C_R, A_SUB,
              32'd0, 1'b1, 1'b0, 1'b0, 3);
        issue("m1_r10", mki(5'd0, 5'd10, 16'hFFFF), C_I, A_ADD,
              32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3);
        issue("slt", mki(5'd10, 5'd12, 16'h0001), C_I, A_SLT,
              32'd1, 1'b0, 1'b0, 1'b0, 3);
        wait_idle();
        chk_reg("r8", 5'd8, 32'h80000000);
        chk_reg("r12", 5'd12, 32'd1);

        issue("lw_misalign", mki(5'd0, 5'd4, 16'h0006), C_LW, A_ADD,
              32'd0, 1'b0, 1'b0, 1'b1, 4);
        issue("lw_range", mki(5'd0, 5'd4, 16'h0400), C_LW, A_ADD,
              32'd0, 1'b0, 1'b0, 1'b1, 4);
        issue("illegal", mki(5'd1, 5'd13, 16'h0005), C_I, A_BAD,
              32'd0, 1'b1, 1'b0, 1'b1, 2);
        issue("rd_and_wr", mki(5'd0, 5'd3, 16'h0008), C_RW, A_ADD,
              32'd8, 1'b0, 1'b0, 1'b1, 3);
        issue("lw_r14", mki(5'd0, 5'd14, 16'h0008), C_LW, A_ADD,
              32'd5, 1'b0, 1'b0, 1'b0, 4);
        wait_idle();
        chk_reg("r4_kept", 5'd4, 32'd5);
        chk_reg("r13_none", 5'd13, 32'd0);
        chk_reg("r14", 5'd14, 32'd5);

        issue("w_r0", mki(5'd0, 5'd0, 16'h1234), C_I, A_ADD,
              32'h1234, 1'b0, 1'b0, 1'b0, 3);
        issue("r0_read", mkr(5'd0, 5'd0, 5'd15), C_R, A_ADD,
              32'd0, 1'b1, 1'b0, 1'b0, 3);
        wait_idle();
        chk_reg("r0", 5'd0, 32'd0);

        repeat (10) @(negedge clk);
        chk("idle.ready", 32'(bus.instr_ready), 32'd1);
        chk("idle.pending", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
